eth_fcs_check: RTL and testbench
================================

// Module: eth_fcs_check
// PURPOSE
//  Receive-side Ethernet FCS checker, the counterpart of the TX CRC32 generator.
//  Sits between the RX byte stream (after preamble/SFD strip) and the MAC RX parser.
//  Computes CRC32 over every frame byte, including the received FCS, and strips the 4 FCS bytes.
//  Emits the payload stream with an end marker and a one-cycle frame status.
// PARAMETERS
//  MIN_BYTES  64    minimum legal frame length in bytes, FCS included
//  MAX_BYTES  1518  maximum legal frame length in bytes, FCS included
//  CNT_W      16    width of the byte counter and of frame_len
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst_n      in   1      reset, asynchronous, active-low
//  rx_dv      in   1      frame envelope; high from the first byte through the last FCS byte
//  rx_valid   in   1      byte strobe; qualified by rx_dv; gaps are allowed
//  rx_data    in   8      frame byte, LSB is the first bit on the wire
//  rx_er      in   1      PHY error; sticky for the current frame when sampled with rx_dv
//  out_data   out  8      payload byte (FCS stripped)
//  out_valid  out  1      out_data is valid this cycle
//  out_last   out  1      out_data is the last payload byte of the frame
//  frame_done out  1      one-cycle pulse; the status outputs below are valid only in this cycle
//  frame_good out  1      frame passed all checks: fcs_err=0, phy_err=0, len_err=0
//  fcs_err    out  1      FCS residue mismatch, or fewer than 4 bytes received
//  phy_err    out  1      rx_er was seen during the frame
//  len_err    out  1      byte count < MIN_BYTES or > MAX_BYTES
//  frame_len  out  CNT_W  payload byte count (total - 4); 0 if total < 4
// BEHAVIOUR
//  - All outputs are registered. Asynchronous reset forces every output to 0, the CRC register
//    to 32'hFFFFFFFF, the byte count and delay buffer to empty, and the state to WAIT_IDLE.
//  - CRC model: reflected CRC32, polynomial 0xEDB88320, init 0xFFFFFFFF, LSB of each byte first.
//    One byte is processed per accepted strobe.
//  - Good FCS iff the register after the last byte equals 32'hDEBB20E3 (residue, no final XOR).
//  - Byte accepted iff rx_dv && rx_valid in a cycle where the state is IDLE or RECV.
//    rx_valid with rx_dv low is ignored.
//  - FSM:
//      WAIT_IDLE -> IDLE when rx_dv == 0.
//      IDLE -> RECV when rx_dv == 1; a byte strobed in that same cycle is accepted.
//      RECV -> IDLE when rx_dv == 0 is sampled; this is the end event.
//  - Delay buffer: 5 bytes deep.
//      An accepted byte while 5 are held shifts out the oldest byte:
//      out_valid = 1 and out_data = oldest byte in the next cycle.
//      Latency: byte k appears one cycle after byte k+5 is accepted.
//  - End event (rx_dv sampled 0 in RECV). The next cycle shows:
//      frame_done = 1 with all status outputs.
//      If 5 bytes are held: out_valid = 1, out_last = 1, out_data = oldest byte.
//      If fewer than 5 are held: no data is output.
//      The remaining 4 FCS bytes are discarded.
//      The CRC register re-initialises, and the count and buffer clear, in the same edge.
//  - A frame of exactly 4 bytes gives frame_done with frame_len = 0 and no data output.
//  - Byte counter saturates at all-ones and never wraps.
//    A saturated count sets len_err through the MAX_BYTES check.
//  - frame_good = !fcs_err && !phy_err && !len_err.
//    Every status output other than frame_done holds 0 when frame_done = 0.
//  - A byte strobed in the same cycle that rx_dv falls is not accepted.
//  - Back-to-back frames with one idle cycle (rx_dv low for one cycle) are supported.
//  - Reset mid-frame: the frame is dropped with no frame_done.
//    After reset release, a frame is received only after rx_dv is sampled low (WAIT_IDLE).
// TESTING
//  T1 MIN_BYTES=8. Frame 31..39 then 26 39 F4 CB, one byte per cycle.
//     -> out bytes 31..39, out_last on 39, frame_done, frame_good=1, fcs_err=0, frame_len=9.
//  T2 Same frame with rx_data bit0 of byte 35 flipped.
//     -> frame_done, fcs_err=1, frame_good=0, data still forwarded.
//  T3 T1 frame with rx_valid every 3rd cycle, then back-to-back with a second copy after a
//     1-cycle rx_dv gap -> two identical good frame_done pulses and identical streams.
//  T4 Default params, T1 frame (13 bytes) -> len_err=1, fcs_err=0, frame_good=0.
//     A 3-byte frame -> fcs_err=1, len_err=1, frame_len=0, no out_valid.
//  T5 rx_er pulsed on byte 3 of the T1 frame -> phy_err=1, frame_good=0.
//     The next frame is clean: phy_err=0.
//  T6 rst_n pulsed low during byte 6 of T1 while rx_dv stays high -> no frame_done for it.
//     Then a full T1 frame after rx_dv goes low -> frame_good=1.

Source files
------------

// File: rtl/eth_fcs_check_if.sv
// Bus bundle for the receive-side Ethernet FCS checker.
//   rx_dv/rx_valid/rx_data/rx_er : byte stream from the PHY side (after preamble/SFD strip)
//   out_data/out_valid/out_last  : payload stream towards the MAC RX parser (FCS stripped)
//   frame_done + status          : one-cycle end-of-frame status
// master: drives the RX stream and observes results; slave: the checker itself.
interface eth_fcs_check_if #(
  parameter int unsigned CNT_W = 16
);
  logic             rx_dv;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_er;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             frame_done;
  logic             frame_good;
  logic             fcs_err;
  logic             phy_err;
  logic             len_err;
  logic [CNT_W-1:0] frame_len;

  modport master (
    output rx_dv, rx_valid, rx_data, rx_er,
    input  out_data, out_valid, out_last,
    input  frame_done, frame_good, fcs_err, phy_err, len_err, frame_len
  );

  modport slave (
    input  rx_dv, rx_valid, rx_data, rx_er,
    output out_data, out_valid, out_last,
    output frame_done, frame_good, fcs_err, phy_err, len_err, frame_len
  );
endinterface

// File: rtl/eth_fcs_check.sv
// Receive-side Ethernet FCS checker.
// Runs a reflected CRC32 over every accepted frame byte (FCS included), holds the
// last 5 bytes in a delay line so the 4 FCS bytes can be dropped and the final
// payload byte flagged with out_last, and reports a one-cycle frame status.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : eth_fcs_check_if.slave (RX stream in, payload stream + status out)
module eth_fcs_check #(
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned MAX_BYTES = 1518,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  eth_fcs_check_if.slave bus
);

  localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
  localparam int unsigned      DEPTH       = 5;
  localparam logic [2:0]       DEPTH_V     = 3'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_FCS     = CNT_W'(4);
  localparam logic [CNT_W-1:0] CNT_MIN     = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0] CNT_LIM     = CNT_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             crc_q, crc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              held_q, held_d;
  logic [DEPTH-1:0][7:0]   buf_q, buf_d;   // [0] is the oldest byte
  logic                    phy_q, phy_d;   // sticky rx_er for the current frame

  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic                    good_q, good_d;
  logic                    fcs_err_q, fcs_err_d;
  logic                    phy_err_q, phy_err_d;
  logic                    len_err_q, len_err_d;
  logic [CNT_W-1:0]        flen_q, flen_d;

  logic                    accept;
  logic                    end_evt;
  logic                    fcs_bad;
  logic                    len_bad;

  // One byte through the reflected CRC32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC_POLY : '0);
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    buf_d       = buf_q;
    phy_d       = phy_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    good_d      = 1'b0;
    fcs_err_d   = 1'b0;
    phy_err_d   = 1'b0;
    len_err_d   = 1'b0;
    flen_d      = '0;

    accept  = bus.rx_dv && bus.rx_valid && ((state_q == IDLE) || (state_q == RECV));
    end_evt = (state_q == RECV) && !bus.rx_dv;
    fcs_bad = (crc_q != CRC_RESIDUE) || (cnt_q < CNT_FCS);
    len_bad = (cnt_q < CNT_MIN) || (cnt_q > CNT_LIM);

    unique case (state_q)
      WAIT_IDLE: if (!bus.rx_dv) state_d = IDLE;
      IDLE:      if (bus.rx_dv)  state_d = RECV;
      RECV:      if (!bus.rx_dv) state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase

    if (bus.rx_dv && bus.rx_er && (state_q != WAIT_IDLE)) phy_d = 1'b1;

    if (accept) begin
      crc_d = crc32_byte(crc_q, bus.rx_data);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (held_q == DEPTH_V) begin
        // Delay line full: the oldest byte is certainly payload, release it.
        out_valid_d = 1'b1;
        out_data_d  = buf_q[0];
        buf_d       = {bus.rx_data, buf_q[DEPTH-1:1]};
      end else begin
        buf_d[held_q] = bus.rx_data;
        held_d        = held_q + 3'd1;
      end
    end

    if (end_evt) begin
      // The 4 newest held bytes are the FCS; only a 5th (oldest) one is payload.
      done_d    = 1'b1;
      fcs_err_d = fcs_bad;
      len_err_d = len_bad;
      phy_err_d = phy_q;
      good_d    = !fcs_bad && !len_bad && !phy_q;
      flen_d    = (cnt_q >= CNT_FCS) ? (cnt_q - CNT_FCS) : '0;
      if (held_q == DEPTH_V) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_data_d  = buf_q[0];
      end
      crc_d  = '1;
      cnt_d  = '0;
      held_d = '0;
      buf_d  = '0;
      phy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_IDLE;
      crc_q       <= '1;
      cnt_q       <= '0;
      held_q      <= '0;
      buf_q       <= '0;
      phy_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      fcs_err_q   <= 1'b0;
      phy_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      flen_q      <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      buf_q       <= buf_d;
      phy_q       <= phy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      good_q      <= good_d;
      fcs_err_q   <= fcs_err_d;
      phy_err_q   <= phy_err_d;
      len_err_q   <= len_err_d;
      flen_q      <= flen_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = done_q;
  assign bus.frame_good = good_q;
  assign bus.fcs_err    = fcs_err_q;
  assign bus.phy_err    = phy_err_q;
  assign bus.len_err    = len_err_q;
  assign bus.frame_len  = flen_q;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Bench for eth_fcs_check: three instances share one RX stream
//   A: MIN=8,  MAX=1518, CNT_W=16
//   B: defaults (MIN=64, MAX=1518, CNT_W=16)
//   C: MIN=8,  MAX=200,  CNT_W=8 (counter saturation)
// Expected payload streams and statuses come from a frame-level model.
module tb_eth_fcs_check;

  typedef logic [7:0] bq_t[$];

  localparam int unsigned P_MIN[3] = '{8, 64, 8};
  localparam int unsigned P_MAX[3] = '{1518, 1518, 200};
  localparam int unsigned P_SAT[3] = '{65535, 65535, 255};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_fcs_check_if #(.CNT_W(16)) ifa ();
  eth_fcs_check_if #(.CNT_W(16)) ifb ();
  eth_fcs_check_if #(.CNT_W(8))  ifc ();

  assign ifb.rx_dv    = ifa.rx_dv;
  assign ifb.rx_valid = ifa.rx_valid;
  assign ifb.rx_data  = ifa.rx_data;
  assign ifb.rx_er    = ifa.rx_er;
  assign ifc.rx_dv    = ifa.rx_dv;
  assign ifc.rx_valid = ifa.rx_valid;
  assign ifc.rx_data  = ifa.rx_data;
  assign ifc.rx_er    = ifa.rx_er;

  eth_fcs_check #(.MIN_BYTES(8), .MAX_BYTES(1518), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  eth_fcs_check                                                dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  eth_fcs_check #(.MIN_BYTES(8), .MAX_BYTES(200),  .CNT_W(8))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;

  logic [8:0]  act_out[3][$];
  logic [19:0] act_st[3][$];
  logic [8:0]  exp_out[$];
  logic [19:0] exp_st[3][$];
  logic [19:0] exp_mk[3][$];

  `define MON(I, IF) \
  always @(negedge clk) begin \
    if (IF.out_valid) act_out[I].push_back({IF.out_last, IF.out_data}); \
    if (IF.frame_done) act_st[I].push_back({IF.frame_good, IF.fcs_err, IF.phy_err, IF.len_err, 16'(IF.frame_len)}); \
    else begin \
      checks++; \
      assert (({IF.frame_good, IF.fcs_err, IF.phy_err, IF.len_err, 16'(IF.frame_len)} === 20'h0) && !(IF.out_last && !IF.out_valid)) \
      else begin \
        errors++; \
        $error("FAIL idle_status[%0d] got good/fcs/phy/len=%b%b%b%b len=%0d last=%b valid=%b, expected all 0", \
               I, IF.frame_good, IF.fcs_err, IF.phy_err, IF.len_err, IF.frame_len, IF.out_last, IF.out_valid); \
      end \
    end \
  end

  `MON(0, ifa)
  `MON(1, ifb)
  `MON(2, ifc)

  // Standard Ethernet CRC32 (reflected, init all-ones, final complement) of b[0..n-1].
  function automatic logic [31:0] crc32(input bq_t b, input int unsigned n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (r[0] ^ b[i][k]) r = (r >> 1) ^ 32'hEDB88320;
        else                r = r >> 1;
      end
    end
    return ~r;
  endfunction

  function automatic bq_t with_fcs(input bq_t pl);
    bq_t r;
    logic [31:0] c;
    r = pl;
    c = crc32(pl, pl.size());
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(c[31:24]);
    return r;
  endfunction

  // Frame-level expectation: FCS is the CRC of the leading bytes sent LSB-byte first.
  task automatic expect_frame(input bq_t fr, input bit er);
    int unsigned n;
    int unsigned cnt;
    bit fcs_ok;
    bit len_bad;
    logic [15:0] flen;
    n = fr.size();
    fcs_ok = 1'b0;
    if (n >= 4) fcs_ok = (crc32(fr, n - 4) == {fr[n-1], fr[n-2], fr[n-3], fr[n-4]});
    if (n >= 5)
      for (int unsigned i = 0; i < n - 4; i++) exp_out.push_back({(i == n - 5), fr[i]});
    for (int unsigned k = 0; k < 3; k++) begin
      cnt     = (n > P_SAT[k]) ? P_SAT[k] : n;
      len_bad = (cnt < P_MIN[k]) || (cnt > P_MAX[k]);
      flen    = (cnt >= 4) ? 16'(cnt - 4) : 16'd0;
      exp_st[k].push_back({(fcs_ok && !er && !len_bad), !fcs_ok, er, len_bad, flen});
      // Payload length is unrepresentable once the counter saturates; only the flags are compared.
      exp_mk[k].push_back((n > P_SAT[k]) ? 20'hF0000 : 20'hFFFFF);
    end
  endtask

  // gap < 0 gives random 0..2 empty cycles before each byte.
  task automatic send(input bq_t fr, input int gap, input int er_idx, input int unsigned idle);
    int g;
    if (fr.size() == 0) begin
      @(negedge clk);
      ifa.rx_dv = 1'b1; ifa.rx_valid = 1'b0; ifa.rx_er = 1'b0;
    end
    foreach (fr[i]) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(negedge clk);
        ifa.rx_dv = 1'b1; ifa.rx_valid = 1'b0; ifa.rx_data = 8'($urandom); ifa.rx_er = 1'b0;
      end
      @(negedge clk);
      ifa.rx_dv = 1'b1; ifa.rx_valid = 1'b1; ifa.rx_data = fr[i]; ifa.rx_er = (i == er_idx);
    end
    repeat (idle) begin
      @(negedge clk);
      ifa.rx_dv = 1'b0; ifa.rx_valid = 1'($urandom_range(0, 1));
      ifa.rx_data = 8'($urandom); ifa.rx_er = 1'($urandom_range(0, 1));
    end
    expect_frame(fr, (er_idx >= 0) && (er_idx < int'(fr.size())));
  endtask

  task automatic check_all(input string tag);
    int unsigned m;
    ifa.rx_dv = 1'b0; ifa.rx_valid = 1'b0; ifa.rx_er = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      checks++;
      assert (act_out[k].size() === exp_out.size()) else begin
        errors++;
        $error("FAIL %s out_count[%0d] got %0d expected %0d", tag, k, act_out[k].size(), exp_out.size());
      end
      m = (act_out[k].size() < exp_out.size()) ? act_out[k].size() : exp_out.size();
      for (int unsigned i = 0; i < m; i++) begin
        checks++;
        assert (act_out[k][i] === exp_out[i]) else begin
          errors++;
          $error("FAIL %s out_byte[%0d][%0d] got last/data %h expected %h", tag, k, i, act_out[k][i], exp_out[i]);
        end
      end
      checks++;
      assert (act_st[k].size() === exp_st[k].size()) else begin
        errors++;
        $error("FAIL %s done_count[%0d] got %0d expected %0d", tag, k, act_st[k].size(), exp_st[k].size());
      end
      m = (act_st[k].size() < exp_st[k].size()) ? act_st[k].size() : exp_st[k].size();
      for (int unsigned i = 0; i < m; i++) begin
        checks++;
        assert ((act_st[k][i] & exp_mk[k][i]) === (exp_st[k][i] & exp_mk[k][i])) else begin
          errors++;
          $error("FAIL %s status[%0d][%0d] got good/fcs/phy/len+len %h expected %h", tag, k, i,
                 act_st[k][i] & exp_mk[k][i], exp_st[k][i] & exp_mk[k][i]);
        end
      end
      act_out[k].delete(); act_st[k].delete(); exp_st[k].delete(); exp_mk[k].delete();
    end
    exp_out.delete();
  endtask

  function automatic bq_t rand_bytes(input int unsigned n);
    bq_t r;
    for (int unsigned i = 0; i < n; i++) r.push_back(8'($urandom));
    return r;
  endfunction

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bq_t t1, t2, fr;
    int unsigned n, bi;
    t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    ifa.rx_dv = 1'b0; ifa.rx_valid = 1'b0; ifa.rx_data = '0; ifa.rx_er = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checks++;
    assert ({ifa.out_valid, ifa.out_last, ifa.frame_done, ifa.frame_good, ifa.fcs_err} === 5'b0) else begin
      errors++; $error("FAIL reset_flags got %b expected 00000",
                       {ifa.out_valid, ifa.out_last, ifa.frame_done, ifa.frame_good, ifa.fcs_err});
    end
    checks++;
    assert (ifa.out_data === 8'h00) else begin
      errors++; $error("FAIL reset_data got %h expected 00", ifa.out_data);
    end
    checks++;
    assert (ifc.frame_len === 8'h00 && ifb.frame_len === 16'h0) else begin
      errors++; $error("FAIL reset_len got %0d/%0d expected 0", ifb.frame_len, ifc.frame_len);
    end

    // Release reset with rx_dv already high: that frame must be ignored (WAIT_IDLE)
    ifa.rx_dv = 1'b1; ifa.rx_valid = 1'b1; ifa.rx_data = 8'hA5;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ifa.rx_dv = 1'b0;
    repeat (2) @(negedge clk);
    check_all("post_reset_dv_high");

    send(t1, 0, -1, 3);
    check_all("t1_good");

    t2 = t1;
    t2[4] = t2[4] ^ 8'h01;
    send(t2, 0, -1, 3);
    check_all("t2_bad_fcs");

    send(t1, 2, -1, 1);
    send(t1, 2, -1, 3);
    check_all("t3_gaps_b2b");

    send(rand_bytes(3), 0, -1, 2);
    send(rand_bytes(4), 0, -1, 2);
    send(with_fcs(rand_bytes(0)), 0, -1, 2);
    fr.delete();
    send(fr, 0, -1, 2);
    send(with_fcs(rand_bytes(1)), -1, -1, 2);
    send(with_fcs(rand_bytes(59)), 0, -1, 1);
    send(with_fcs(rand_bytes(60)), 0, -1, 1);
    check_all("t4_short_min");

    send(with_fcs(rand_bytes(1514)), 0, -1, 1);
    send(with_fcs(rand_bytes(1515)), 0, -1, 1);
    send(with_fcs(rand_bytes(196)), 0, -1, 1);
    send(with_fcs(rand_bytes(197)), 0, -1, 1);
    send(with_fcs(rand_bytes(296)), 0, -1, 2);
    check_all("t4_max_sat");

    send(t1, 0, 2, 1);
    send(t1, 0, -1, 2);
    check_all("t5_phy_err");

    // Reset while the 6th byte of a frame is on the bus, rx_dv held high throughout
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      ifa.rx_dv = 1'b1; ifa.rx_valid = 1'b1; ifa.rx_data = t1[i]; ifa.rx_er = 1'b0;
    end
    @(negedge clk);
    ifa.rx_data = t1[5]; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 6; i < 13; i++) begin
      ifa.rx_data = t1[i];
      @(negedge clk);
    end
    ifa.rx_dv = 1'b0; ifa.rx_valid = 1'b0;
    @(negedge clk);
    send(t1, 0, -1, 2);
    check_all("t6_reset_mid");

    // Randomised frames, mostly back-to-back
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned f = 0; f < 15; f++) begin
        n = $urandom_range(0, 80);
        if (n < 4) fr = rand_bytes(n);
        else       fr = with_fcs(rand_bytes(n - 4));
        if (n > 0 && $urandom_range(0, 3) == 0) begin
          bi = $urandom_range(0, n - 1);
          fr[bi] = fr[bi] ^ (8'h01 << $urandom_range(0, 7));
        end
        send(fr, -1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 80)) : -1,
             $urandom_range(1, 3));
      end
      check_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
